// File: rtl/gb_cpu_interrupt_ctrl.sv
// Game Boy CPU interrupt controller.
// Holds IF/IE, sequences IME (OFF -> ARMED -> ON, so EI takes effect one
// instruction late), flags HALT wake, and runs the start/commit dispatch
// handshake. The vector is picked from live IF & IE in the commit cycle, so
// register changes during the ISR push can redirect or cancel a dispatch.
module gb_cpu_interrupt_ctrl #(
  parameter int unsigned NUM_IRQ       = 5,
  parameter logic [7:0]  VECTOR_BASE   = 8'h40,
  parameter logic [7:0]  VECTOR_STRIDE = 8'h08
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               reg_wr_en,
  input  logic               reg_wr_sel,
  input  logic [7:0]         reg_wr_data,
  output logic [7:0]         reg_IF,
  output logic [7:0]         reg_IE,
  input  logic               ei_i,
  input  logic               di_i,
  input  logic               reti_i,
  input  logic               instr_boundary_i,
  input  logic               dispatch_start_i,
  input  logic               dispatch_commit_i,
  output logic               int_pending,
  output logic               wake,
  output logic               ime,
  output logic               dispatch_busy,
  output logic [7:0]         vector
);

  typedef enum logic [1:0] {
    IME_OFF   = 2'd0,
    IME_ARMED = 2'd1,
    IME_ON    = 2'd2
  } ime_state_e;

  typedef enum logic {
    DSP_IDLE   = 1'b0,
    DSP_ACTIVE = 1'b1
  } dsp_state_e;

  // Stored request/enable state and the latched vector.
  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic [7:0]         vector_q, vector_d;

  // FSM state plus the registered outputs that mirror it.
  ime_state_e         ime_st_q;
  logic               ime_q;
  dsp_state_e         dsp_st_q;
  logic               busy_q;

  // Combinational helpers.
  logic [NUM_IRQ-1:0] pend_bits;
  logic               any_pend;
  logic [3:0]         low_sel;     // bit 3 set means no line is pending
  logic               commit;
  logic [NUM_IRQ-1:0] commit_clr;

  // Lowest pending line wins; bit 3 of the result flags "none pending".
  function automatic logic [3:0] lowest_set(input logic [NUM_IRQ-1:0] bits);
    logic [3:0] r;
    r = 4'h8;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (bits[i]) r = {1'b0, 3'(i)};
    end
    return r;
  endfunction

  // ISR vector for line k; the 8-bit arithmetic wraps modulo 256 on purpose.
  function automatic logic [7:0] vec_of(input logic [2:0] k);
    logic [7:0] off;
    off = 8'(k) * VECTOR_STRIDE;
    return VECTOR_BASE + off;
  endfunction

  // Pending-line selection and the one-hot clear applied on commit.
  always_comb begin
    pend_bits  = if_q & ie_q[NUM_IRQ-1:0];
    any_pend   = |pend_bits;
    low_sel    = lowest_set(pend_bits);
    commit     = (dsp_st_q == DSP_ACTIVE) && dispatch_commit_i;
    commit_clr = '0;
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      commit_clr[i] = commit && !low_sel[3] && (low_sel[2:0] == 3'(i));
    end
  end

  // Next IF/IE/vector: write, then commit clear, then new requests on top
  // so a request pulse always survives a clear of the same bit.
  always_comb begin
    if_d = if_q;
    if (reg_wr_en && !reg_wr_sel) if_d = reg_wr_data[NUM_IRQ-1:0];
    if_d = (if_d & ~commit_clr) | irq_i;

    ie_d = ie_q;
    if (reg_wr_en && reg_wr_sel) ie_d = reg_wr_data;

    vector_d = vector_q;
    if (commit) vector_d = low_sel[3] ? 8'h00 : vec_of(low_sel[2:0]);
  end

  // Register state; a reset mid-dispatch simply drops the dispatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_q     <= '0;
      ie_q     <= 8'h00;
      vector_q <= 8'h00;
    end else begin
      if_q     <= if_d;
      ie_q     <= ie_d;
      vector_q <= vector_d;
    end
  end

  // IME sequencing: start/DI beat RETI, RETI beats EI, EI beats the boundary
  // advance, so an EI on a boundary waits for the following boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      ime_st_q <= IME_OFF;
      ime_q    <= 1'b0;
    end else if (dispatch_start_i || di_i) begin
      ime_st_q <= IME_OFF;
      ime_q    <= 1'b0;
    end else if (reti_i) begin
      ime_st_q <= IME_ON;
      ime_q    <= 1'b1;
    end else if (ei_i) begin
      if (ime_st_q == IME_OFF) ime_st_q <= IME_ARMED;
    end else if ((ime_st_q == IME_ARMED) && instr_boundary_i) begin
      ime_st_q <= IME_ON;
      ime_q    <= 1'b1;
    end
  end

  // Dispatch handshake: start opens, commit closes; strays are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      dsp_st_q <= DSP_IDLE;
      busy_q   <= 1'b0;
    end else begin
      case (dsp_st_q)
        DSP_IDLE: begin
          if (dispatch_start_i) begin
            dsp_st_q <= DSP_ACTIVE;
            busy_q   <= 1'b1;
          end
        end
        DSP_ACTIVE: begin
          if (dispatch_commit_i) begin
            dsp_st_q <= DSP_IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          dsp_st_q <= DSP_IDLE;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  // Readback and status; unimplemented IF bits read as 1.
  always_comb begin
    reg_IF              = 8'hFF;
    reg_IF[NUM_IRQ-1:0] = if_q;
    reg_IE              = ie_q;
    wake                = any_pend;
    int_pending         = any_pend &&
                          (ime_q || ((ime_st_q == IME_ARMED) && instr_boundary_i && !ei_i));
    ime                 = ime_q;
    dispatch_busy       = busy_q;
    vector              = vector_q;
  end

endmodule

// File: doc/gb_cpu_interrupt_ctrl.md
# gb_cpu_interrupt_ctrl

Parametrised interrupt controller for the Game Boy CPU core. It owns the IF and IE registers for up to 8 request lines and the IME state machine, including the one-instruction EI delay. It provides HALT wake and a two-step dispatch handshake with the scheduler. The vector is latched late, so IE/IF changes during the ISR push redirect or cancel the dispatch, as on hardware.

## Interface
- NUM_IRQ, 5, number of request lines (1..8); IF/IE bit i is line i, bit 0 has the highest priority
- VECTOR_BASE, 8'h40, vector of line 0
- VECTOR_STRIDE, 8'h08, vector spacing between lines
- clk  in  1  machine (M) clock; the only clock
- reset  in  1  synchronous, active-high reset
- irq_i  in  NUM_IRQ  request pulses; each high cycle sets the matching IF bit
- reg_wr_en  in  1  register write strobe
- reg_wr_sel  in  1  0 = IF, 1 = IE
- reg_wr_data  in  8  write data
- reg_IF  out  8  IF readback; bits >= NUM_IRQ read 1
- reg_IE  out  8  IE readback; all 8 bits stored
- ei_i, di_i, reti_i  in  1  instruction strobes, one cycle each
- instr_boundary_i  in  1  high in the m-cycle where the CPU decides between next-opcode fetch and dispatch
- dispatch_start_i  in  1  CPU begins the ISR sequence
- dispatch_commit_i  in  1  CPU takes the vector (cycle before the PC load)
- int_pending  out  1  interrupt must be taken at this boundary
- wake  out  1  (IF & IE)[NUM_IRQ-1:0] != 0, independent of IME
- ime  out  1  IME == ON
- dispatch_busy  out  1  dispatch FSM is ACTIVE
- vector  out  8  latched ISR vector

## Operation
- **any:** |(IF & IE) over the low NUM_IRQ bits.
- **IF update, per cycle:**
  - Start from the stored value, or from reg_wr_data if IF is written.
  - Clear the committed bit, if there is one.
  - OR in irq_i. A request set wins over a write-clear and over a commit-clear of the same bit.
- **IE update:** IE <= reg_wr_data on write.
- **IME FSM states:** OFF, ARMED, ON. Priority per cycle is dispatch_start_i > di_i > reti_i > ei_i > boundary advance.
  - dispatch_start_i or di_i: go to OFF, from any state. This cancels ARMED.
  - reti_i: go to ON immediately.
  - ei_i: OFF goes to ARMED. ARMED and ON hold.
  - ARMED with instr_boundary_i, and no ei_i in the same cycle: go to ON.
- **int_pending:** any && (ime || (state == ARMED && instr_boundary_i && !ei_i)). Exactly one instruction after EI executes before a dispatch.
- **Dispatch FSM states:** IDLE, ACTIVE.
  - IDLE with dispatch_start_i: go to ACTIVE.
  - ACTIVE with dispatch_commit_i: go to IDLE.
  - dispatch_start_i in ACTIVE is ignored. dispatch_commit_i in IDLE is ignored.
- **Commit, evaluated on live IF & IE in the commit cycle:**
  - Lowest set index k present: vector <= VECTOR_BASE + k*VECTOR_STRIDE (8-bit, wraps mod 256), and IF[k] is cleared.
  - None set: vector <= 8'h00 and nothing is cleared (cancelled dispatch).
- **Reset:** IF = 0 (reg_IF = 8'hE0 when NUM_IRQ = 5), IE = 0, IME state OFF, dispatch IDLE, vector = 8'h00. Therefore ime = 0, dispatch_busy = 0, int_pending = 0, wake = 0. Reset mid-dispatch returns to IDLE with no IF clear.

## Timing
- All state is registered on posedge clk.
- int_pending and wake are combinational from registered state, plus instr_boundary_i and ei_i for the ARMED term.
- irq_i / register write at edge N: wake is visible in cycle N+1.
- reg_IF / reg_IE reflect writes one cycle after the write edge.
- dispatch_busy rises the cycle after dispatch_start_i and falls the cycle after dispatch_commit_i.
- vector and the IF clear are visible the cycle after commit. vector holds until the next commit or reset.
- ime drops the cycle after dispatch_start_i / di_i and rises the cycle after reti_i.
- Minimum dispatch: start and commit in consecutive cycles is legal.

## Test plan
- **Reset:** reset held 2 cycles with irq_i = all-1 -> reg_IF = 8'hE0, reg_IE = 0, ime = 0, vector = 0, dispatch_busy = 0.
- **EI delay:**
  - Setup: IE = 8'h01, IF[0] = 1.
  - ei_i at boundary b0 -> int_pending = 0 at b0.
  - At the next boundary b1 -> int_pending = 1; after the b1 edge, ime = 1.
  - di_i between b0 and b1 -> int_pending stays 0 at b1.
- **Priority and clear:**
  - IE = 8'h1F, IF = 8'h14; start, then commit -> vector = 8'h50, reg_IF = 8'hF0, ime = 0.
  - Second dispatch -> vector = 8'h60.
- **Cancelled dispatch:** start with IF = 8'h01 and IE = 8'h01; IE written to 0 before commit -> vector = 8'h00, reg_IF unchanged (8'hE1).
- **Set/clear collision:**
  - irq_i[2] in the same cycle as a commit selecting bit 2 -> IF[2] remains 1.
  - IF write of 0 with irq_i[1] in the same cycle -> IF[1] = 1.
- **Parameters and HALT wake:**
  - NUM_IRQ = 8, VECTOR_BASE = 8'hF0: IF[7] only -> vector = 8'h28 (wrap).
  - With ime = 0, irq_i[3] with IE[3] = 1 -> wake = 1, int_pending = 0.
